ps2_key_tracker: RTL

Receives PS/2 keyboard frames and keeps a live 512-entry pressed-key map. It sits directly upstream of the speed controller and the other keyboard-driven controllers, and produces the `key_down`, `last_change` and `key_valid` bundle they consume. It handles the E0 extended prefix, F0 break codes, frame errors and stalled frames.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_key_tracker_if.sv | 32 +++
 rtl/ps2_frame_rx.sv | 126 ++++++++++++
 rtl/ps2_key_tracker.sv | 78 +++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_pkg : shared constants and frame-state encoding for PS/2 rx      |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam int         PS2_CODE_W       = 9;
  localparam int         PS2_MAP_W        = 1 << PS2_CODE_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_key_tracker_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_key_tracker_if : raw PS/2 pins plus the key-map output bundle    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
interface ps2_key_tracker_if;
  import ps2_pkg::*;

  logic                  PS2_CLK;
  logic                  PS2_DATA;
  logic [PS2_MAP_W-1:0]  key_down;
  logic [PS2_CODE_W-1:0] last_change;
  logic                  key_valid;

  modport master (
    input  PS2_CLK,
    input  PS2_DATA,
    output key_down,
    output last_change,
    output key_valid
  );

  modport slave (
    output PS2_CLK,
    output PS2_DATA,
    input  key_down,
    input  last_change,
    input  key_valid
  );

endinterface : ps2_key_tracker_if
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_frame_rx : sync, clock filter, 11-bit frame FSM with timeout     |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       PS2_CLK,
  input  wire logic       PS2_DATA,
  output logic            byte_valid,
  output logic [7:0]      rx_byte
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FW-1:0] flt_cnt_q;
  logic          level_q, level_prev_q;
  logic          w_strobe;
  logic          w_timeout;

  frame_state_t  state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] to_cnt_q;
  logic          byte_valid_q;
  logic [7:0]    rx_byte_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      flt_cnt_q    <= '0;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
    end else begin
      clk_s1_q     <= PS2_CLK;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= PS2_DATA;
      dat_s2_q     <= dat_s1_q;
      level_prev_q <= level_q;
      if (clk_s2_q == level_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        level_q   <= clk_s2_q;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  assign w_strobe  = level_prev_q & ~level_q;
  assign w_timeout = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      rx_byte_q    <= '0;
    end else begin
      byte_valid_q <= 1'b0;
      if (state_q == ST_IDLE || w_strobe) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (w_strobe && !dat_s2_q) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
          end
        end
        ST_DATA: begin
          if (w_strobe) begin
            shift_q   <= {dat_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (w_strobe) begin
            parity_q <= dat_s2_q;
            state_q  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_strobe) begin
            if (dat_s2_q && (^{shift_q, parity_q})) begin
              byte_valid_q <= 1'b1;
              rx_byte_q    <= shift_q;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A strobe landing on the timeout cycle keeps the frame alive.
      if (state_q != ST_IDLE && !w_strobe && w_timeout) begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign byte_valid = byte_valid_q;
  assign rx_byte    = rx_byte_q;

endmodule : ps2_frame_rx
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_key_tracker : PS/2 scan-code decoder keeping a 512-key map       |
// | Option macro: PS2_TYPEMATIC_FILTER_EN (suppress auto-repeat makes)   |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ps2_key_tracker_if.master bus
);

  logic                  w_byte_valid;
  logic [7:0]            w_rx_byte;
  logic [PS2_CODE_W-1:0] w_code;

  logic                  ext_q, brk_q;
  logic [PS2_MAP_W-1:0]  key_down_q;
  logic [PS2_CODE_W-1:0] last_change_q;
  logic                  key_valid_q;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .PS2_CLK    (bus.PS2_CLK),
    .PS2_DATA   (bus.PS2_DATA),
    .byte_valid (w_byte_valid),
    .rx_byte    (w_rx_byte)
  );

  assign w_code = {ext_q, w_rx_byte};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      key_down_q    <= '0;
      last_change_q <= '0;
      key_valid_q   <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (w_byte_valid) begin
        if (w_rx_byte == PS2_EXT_PREFIX) begin
          ext_q <= 1'b1;
        end else if (w_rx_byte == PS2_BREAK_PREFIX) begin
          brk_q <= 1'b1;
        end else begin
          ext_q              <= 1'b0;
          brk_q              <= 1'b0;
          key_down_q[w_code] <= !brk_q;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (brk_q || !key_down_q[w_code]) begin
            last_change_q <= w_code;
            key_valid_q   <= 1'b1;
          end
`else
          last_change_q <= w_code;
          key_valid_q   <= 1'b1;
`endif
        end
      end
    end
  end

  assign bus.key_down    = key_down_q;
  assign bus.last_change = last_change_q;
  assign bus.key_valid   = key_valid_q;

endmodule : ps2_key_tracker
`default_nettype wire
